switch_led_ctrl: RTL and testbench

Parametrised successor to the fixed 4-switch/7-LED top-level I/O logic. It handles N_CH raw board switches, each through a 2-flop synchroniser and a counter debouncer. It drives one LED per channel in one of four run-time display modes: follow, toggle, blink, chase. It sits directly behind the board pins, between the switch/LED pads and the application logic, and also exports debounced levels and rising-edge pulses to that logic.

---
 rtl/switch_led_ctrl.sv | 150 +++++++++++++++
 tb/tb_switch_led_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/switch_led_ctrl.sv
// Board switch/LED front end: per-channel synchroniser + debouncer feeding a
// four-mode LED display (follow, toggle, blink, chase), plus debounced level/edge exports.

module switch_led_lane #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_raw,
   output logic stable,
   output logic rise,
   output logic tog
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d;
   logic             rise_q, rise_d;
   logic             tog_q, tog_d;

   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      rise_d   = 1'b0;
      tog_d    = tog_q ^ rise_q;
      // Any cycle that agrees with the stable level restarts the count.
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            rise_d   = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
         tog_q    <= 1'b0;
      end else begin
         sync1_q  <= sw_raw;
         sync2_q  <= sync1_q;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         rise_q   <= rise_d;
         tog_q    <= tog_d;
      end
   end

   assign stable = stable_q;
   assign rise   = rise_q;
   assign tog    = tog_q;

endmodule

module switch_led_ctrl #(
   parameter int N_CH            = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int BLINK_HALF      = 25000000,
   parameter int CNT_W           = 20,
   parameter int BLK_W           = 25
) (
   input  logic            SYSTEMCLOCK,
   input  logic            PUSH_BUTTON_RESET_RAW,
   input  logic [N_CH-1:0] Switch_input,
   input  logic [1:0]      Mode,
   output logic [N_CH-1:0] LED_output,
   output logic [N_CH-1:0] sw_stable,
   output logic [N_CH-1:0] sw_rise
);

   typedef enum logic [1:0] {
      MODE_FOLLOW = 2'd0,
      MODE_TOGGLE = 2'd1,
      MODE_BLINK  = 2'd2,
      MODE_CHASE  = 2'd3
   } mode_e;

   localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_HALF - 1);

   logic [N_CH-1:0]  tog;
   logic [BLK_W-1:0] blk_q, blk_d;
   logic             phase_q, phase_d;
   logic [N_CH-1:0]  chase_q, chase_d, chase_rot;
   logic [N_CH-1:0]  led_q, led_d;
   logic             wrap, any_on;

   for (genvar i = 0; i < N_CH; i++) begin : g_lane
      switch_led_lane #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_lane (
         .clk   (SYSTEMCLOCK),
         .rst_n (PUSH_BUTTON_RESET_RAW),
         .sw_raw(Switch_input[i]),
         .stable(sw_stable[i]),
         .rise  (sw_rise[i]),
         .tog   (tog[i])
      );
   end

   if (N_CH == 1) begin : g_rot1
      assign chase_rot = chase_q;
   end else begin : g_rotn
      assign chase_rot = {chase_q[N_CH-2:0], chase_q[N_CH-1]};
   end

   assign wrap   = (blk_q == BLK_MAX);
   assign any_on = |sw_stable;

   always_comb begin
      blk_d   = wrap ? '0 : blk_q + 1'b1;
      phase_d = phase_q ^ wrap;
      chase_d = chase_q;
      if (wrap && any_on) chase_d = chase_rot;
      led_d = '0;
      case (mode_e'(Mode))
         MODE_FOLLOW: led_d = sw_stable;
         MODE_TOGGLE: led_d = tog;
         MODE_BLINK:  led_d = sw_stable & {N_CH{phase_q}};
         MODE_CHASE:  led_d = any_on ? chase_q : '0;
         default:     led_d = '0;
      endcase
   end

   always_ff @(posedge SYSTEMCLOCK or negedge PUSH_BUTTON_RESET_RAW) begin
      if (!PUSH_BUTTON_RESET_RAW) begin
         blk_q   <= '0;
         phase_q <= 1'b0;
         chase_q <= N_CH'(1);
         led_q   <= '0;
      end else begin
         blk_q   <= blk_d;
         phase_q <= phase_d;
         chase_q <= chase_d;
         led_q   <= led_d;
      end
   end

   assign LED_output = led_q;

endmodule

// File: tb/tb_switch_led_ctrl.sv
// Directed bench for switch_led_ctrl at N_CH=4, DEBOUNCE_CYCLES=4, BLINK_HALF=8.

module tb_switch_led_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] sw_in = '0;
   logic [1:0] Mode = '0;
   logic [3:0] led, stable, rise;
   int checks = 0;
   int failures = 0;

   switch_led_ctrl #(
      .N_CH(4), .DEBOUNCE_CYCLES(4), .BLINK_HALF(8), .CNT_W(3), .BLK_W(4)
   ) dut (
      .SYSTEMCLOCK          (clk),
      .PUSH_BUTTON_RESET_RAW(rst_n),
      .Switch_input         (sw_in),
      .Mode                 (Mode),
      .LED_output           (led),
      .sw_stable            (stable),
      .sw_rise              (rise)
   );

   always #5 clk = ~clk;

   // Leaves the bench just before edge 1 after release, with sw applied.
   task automatic apply_reset(input logic [3:0] sw, input logic [1:0] md);
      rst_n = 1'b0;
      Mode  = md;
      sw_in = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      sw_in = sw;
      rst_n = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [3:0] e_st, e_rs, e_led;
      rst_n = 1'b0; Mode = 2'd0; sw_in = 4'b1111;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if ({led, stable, rise} !== 12'h000) begin
         failures++;
         $display("FAIL reset_outputs got led=%b st=%b rise=%b exp all 0", led, stable, rise);
      end
      @(negedge clk);
      sw_in = 4'b0001;
      rst_n = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         step();
         e_st  = (k >= 6) ? 4'b0001 : 4'b0000;
         e_rs  = (k == 6) ? 4'b0001 : 4'b0000;
         e_led = (k >= 7) ? 4'b0001 : 4'b0000;
         checks++;
         if ({stable, rise, led} !== {e_st, e_rs, e_led}) begin
            failures++;
            $display("FAIL latency edge=%0d got st=%b rise=%b led=%b exp st=%b rise=%b led=%b",
                     k, stable, rise, led, e_st, e_rs, e_led);
         end
      end
   endtask

   task automatic test_glitch();
      logic [3:0] e_st, e_rs;
      apply_reset(4'b0010, 2'd0);
      repeat (3) step();
      sw_in = 4'b0000;
      for (int k = 4; k <= 14; k++) begin
         step();
         checks++;
         if ({stable, rise, led} !== 12'h000) begin
            failures++;
            $display("FAIL glitch3 edge=%0d got st=%b rise=%b led=%b exp 0", k, stable, rise, led);
         end
      end
      // Held long enough to pass: changes at the 6th edge after it is applied.
      sw_in = 4'b0010;
      for (int k = 1; k <= 7; k++) begin
         step();
         e_st = (k >= 6) ? 4'b0010 : 4'b0000;
         e_rs = (k == 6) ? 4'b0010 : 4'b0000;
         checks++;
         if ({stable, rise} !== {e_st, e_rs}) begin
            failures++;
            $display("FAIL glitch6 edge=%0d got st=%b rise=%b exp st=%b rise=%b",
                     k, stable, rise, e_st, e_rs);
         end
      end
      sw_in = 4'b0000;
   endtask

   task automatic test_toggle();
      int n_rise;
      int other;
      logic [3:0] e_led;
      n_rise = 0;
      other  = 0;
      apply_reset(4'b0000, 2'd1);
      for (int n = 0; n < 3; n++) begin
         sw_in = 4'b0100;
         for (int k = 0; k < 10; k++) begin
            step();
            if (rise[2]) n_rise++;
            if (rise[1:0] != 0 || rise[3] || led[1:0] != 0 || led[3]) other++;
         end
         e_led = (n % 2 == 0) ? 4'b0100 : 4'b0000;
         checks++;
         if (led !== e_led) begin
            failures++;
            $display("FAIL toggle_press%0d got led=%b exp %b", n, led, e_led);
         end
         sw_in = 4'b0000;
         for (int k = 0; k < 10; k++) begin
            step();
            if (rise[2]) n_rise++;
            if (rise[1:0] != 0 || rise[3] || led[1:0] != 0 || led[3]) other++;
         end
      end
      checks++;
      if (n_rise != 3) begin
         failures++;
         $display("FAIL toggle_rises got %0d exp 3", n_rise);
      end
      checks++;
      if (led !== 4'b0100 || other != 0) begin
         failures++;
         $display("FAIL toggle_final got led=%b stray=%0d exp led=0100 stray=0", led, other);
      end
   endtask

   task automatic test_blink();
      logic [3:0] e_led;
      apply_reset(4'b0101, 2'd2);
      for (int k = 1; k <= 34; k++) begin
         step();
         e_led = ((k >= 9 && k <= 16) || (k >= 25 && k <= 32)) ? 4'b0101 : 4'b0000;
         checks++;
         if (led !== e_led) begin
            failures++;
            $display("FAIL blink edge=%0d got led=%b exp %b", k, led, e_led);
         end
      end
   endtask

   task automatic test_chase();
      logic [3:0] e_led;
      apply_reset(4'b1000, 2'd3);
      for (int k = 1; k <= 50; k++) begin
         if (k == 21) sw_in = 4'b0000;
         if (k == 41) sw_in = 4'b1000;
         step();
         if (k <= 6)       e_led = 4'b0000;
         else if (k <= 8)  e_led = 4'b0001;
         else if (k <= 16) e_led = 4'b0010;
         else if (k <= 24) e_led = 4'b0100;
         else if (k <= 26) e_led = 4'b1000;
         else if (k <= 46) e_led = 4'b0000;
         else if (k <= 48) e_led = 4'b1000;
         else              e_led = 4'b0001;
         checks++;
         if (led !== e_led) begin
            failures++;
            $display("FAIL chase edge=%0d got led=%b exp %b", k, led, e_led);
         end
      end
   endtask

   task automatic test_async_reset();
      apply_reset(4'b1000, 2'd3);
      for (int k = 1; k <= 10; k++) step();
      checks++;
      if (led !== 4'b0010) begin
         failures++;
         $display("FAIL async_pre got led=%b exp 0010", led);
      end
      sw_in = 4'b1001;
      repeat (4) step();
      // Channel 0 debounce count is now 2; assert reset between edges.
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({led, stable, rise} !== 12'h000) begin
         failures++;
         $display("FAIL async_clear got led=%b st=%b rise=%b exp 0", led, stable, rise);
      end
      apply_reset(4'b1001, 2'd0);
      for (int k = 1; k <= 6; k++) begin
         step();
         if (k == 5) begin
            checks++;
            if (stable !== 4'b0000) begin
               failures++;
               $display("FAIL async_edge5 got st=%b exp 0000", stable);
            end
         end
      end
      checks++;
      if (stable !== 4'b1001 || rise !== 4'b1001) begin
         failures++;
         $display("FAIL async_edge6 got st=%b rise=%b exp 1001/1001", stable, rise);
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_toggle();
      test_blink();
      test_chase();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
